// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART TX frame sequencer.
// UART_TX_STOP2_EN adds a second stop-bit state to the encoding.
package uart_tx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [1:0] MUX_START = 2'b00;
    localparam logic [1:0] MUX_STOP  = 2'b01;
    localparam logic [1:0] MUX_DATA  = 2'b10;
    localparam logic [1:0] MUX_PAR   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
`ifdef UART_TX_STOP2_EN
        ,
        ST_STOP2  = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Control bundle between the frame sequencer and its TX datapath.
// master drives the word strobe/parity enable; slave is the sequencer.
interface uart_tx_ctrl_if;

    logic       DataValid;
    logic       ParEn;
    logic       SerEn;
    logic [1:0] MuxSel;
    logic       Busy;
    logic       FrameDone;

    modport master (
        output DataValid,
        output ParEn,
        input  SerEn,
        input  MuxSel,
        input  Busy,
        input  FrameDone
    );

    modport slave (
        input  DataValid,
        input  ParEn,
        output SerEn,
        output MuxSel,
        output Busy,
        output FrameDone
    );

endinterface

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit counter for the TX sequencer; flags the last data bit.
// Clear has priority over enable.
module uart_tx_bit_cnt #(
    parameter int DATA_WIDTH = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int CW = $clog2(DATA_WIDTH);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_tc = (r_cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_ctrl.sv
// Moore frame sequencer: start, data, optional parity, stop bit(s).
// Build with UART_TX_STOP2_EN for two stop bits.
import uart_tx_pkg::*;

module uart_tx_ctrl #(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input logic           CLK,
    input logic           RST,
    uart_tx_ctrl_if.slave tx_if
);

    state_t r_state;
    state_t w_next;
    logic   r_par_en;
    logic   w_accept;
    logic   w_clr;
    logic   w_en;
    logic   w_tc;

    uart_tx_bit_cnt #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_cnt (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_tc    (w_tc)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state  <= ST_IDLE;
            r_par_en <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_par_en <= tx_if.ParEn;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_clr    = 1'b0;
        w_en     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_if.DataValid) begin
                    w_next   = ST_START;
                    w_accept = 1'b1;
                    w_clr    = 1'b1;
                end
            end
            ST_START: w_next = ST_DATA;
            ST_DATA: begin
                w_en = 1'b1;
                if (w_tc) begin
                    w_clr  = 1'b1;
                    w_next = r_par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: w_next = ST_STOP;
`ifdef UART_TX_STOP2_EN
            ST_STOP: w_next = ST_STOP2;
            ST_STOP2: begin
`else
            ST_STOP: begin
`endif
                // last stop cycle: back-to-back frames skip IDLE
                if (tx_if.DataValid) begin
                    w_next   = ST_START;
                    w_accept = 1'b1;
                    w_clr    = 1'b1;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_if.MuxSel    = MUX_STOP;
        tx_if.Busy      = 1'b0;
        tx_if.SerEn     = 1'b0;
        tx_if.FrameDone = 1'b0;
        case (r_state)
            ST_START: begin
                tx_if.MuxSel = MUX_START;
                tx_if.Busy   = 1'b1;
            end
            ST_DATA: begin
                tx_if.MuxSel = MUX_DATA;
                tx_if.SerEn  = 1'b1;
                tx_if.Busy   = 1'b1;
            end
            ST_PARITY: begin
                tx_if.MuxSel = MUX_PAR;
                tx_if.Busy   = 1'b1;
            end
            ST_STOP: begin
                tx_if.Busy = 1'b1;
`ifndef UART_TX_STOP2_EN
                tx_if.FrameDone = 1'b1;
`endif
            end
`ifdef UART_TX_STOP2_EN
            ST_STOP2: begin
                tx_if.Busy      = 1'b1;
                tx_if.FrameDone = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a frame-queue model.
// Honours UART_TX_STOP2_EN when the design is built with it.
module tb_uart_tx_ctrl;

    localparam int DW = 8;

    typedef struct packed {
        logic [1:0] mux;
        logic       ser;
        logic       busy;
        logic       done;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    int n_err = 0;
    int n_chk = 0;

    exp_t q[$];
    logic last_ser;
    logic last_done;

    uart_tx_ctrl_if tx_if ();

    uart_tx_ctrl #(
        .DATA_WIDTH (DW)
    ) dut (
        .CLK   (CLK),
        .RST   (RST),
        .tx_if (tx_if)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] m, input logic s,
                                input logic b, input logic d);
        exp_t e;
        e.mux  = m;
        e.ser  = s;
        e.busy = b;
        e.done = d;
        return e;
    endfunction

    // A frame is just the list of line symbols it puts out.
    function automatic void push_frame(input logic par);
        q.push_back(mk(2'b00, 1'b0, 1'b1, 1'b0));
        for (int i = 0; i < DW; i++)
            q.push_back(mk(2'b10, 1'b1, 1'b1, 1'b0));
        if (par)
            q.push_back(mk(2'b11, 1'b0, 1'b1, 1'b0));
`ifdef UART_TX_STOP2_EN
        q.push_back(mk(2'b01, 1'b0, 1'b1, 1'b0));
`endif
        q.push_back(mk(2'b01, 1'b0, 1'b1, 1'b1));
    endfunction

    task automatic check_outs(input exp_t e);
        chk("mux",  32'(tx_if.MuxSel),    32'(e.mux));
        chk("ser",  32'(tx_if.SerEn),     32'(e.ser));
        chk("busy", 32'(tx_if.Busy),      32'(e.busy));
        chk("done", 32'(tx_if.FrameDone), 32'(e.done));
    endtask

    // Called at a negedge; drives inputs, advances one bit, checks.
    task automatic step(input logic dv, input logic pe);
        exp_t e;
        tx_if.DataValid = dv;
        tx_if.ParEn     = pe;
        @(posedge CLK);
        if (q.size() > 0)
            void'(q.pop_front());
        if (q.size() == 0 && dv)
            push_frame(pe);
        @(negedge CLK);
        e = (q.size() > 0) ? q[0] : mk(2'b01, 1'b0, 1'b0, 1'b0);
        check_outs(e);
        last_ser  = tx_if.SerEn;
        last_done = tx_if.FrameDone;
    endtask

    // Directed frame: count SerEn cycles and locate FrameDone.
    task automatic frame_stats(input logic pe, input logic flip);
        int n_ser;
        int done_at;
        int exp_len;
        n_ser   = 0;
        done_at = 0;
        exp_len = 2 + DW + (pe ? 1 : 0);
`ifdef UART_TX_STOP2_EN
        exp_len++;
`endif
        step(1'b1, pe);
        if (last_ser) n_ser++;
        for (int i = 2; i <= exp_len + 1; i++) begin
            step(1'b0, flip ? ~pe : pe);
            if (last_ser) n_ser++;
            if (last_done && done_at == 0) done_at = i;
        end
        chk("ser_cnt", 32'(n_ser), 32'(DW));
        chk("done_cyc", 32'(done_at), 32'(exp_len));
    endtask

    initial begin
        exp_t idle_e;
        idle_e = mk(2'b01, 1'b0, 1'b0, 1'b0);
        tx_if.DataValid = 1'b0;
        tx_if.ParEn     = 1'b0;
        last_ser  = 1'b0;
        last_done = 1'b0;

        repeat (2) @(negedge CLK);
        check_outs(idle_e);
        RST = 1'b1;

        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1);

        frame_stats(1'b1, 1'b0);
        frame_stats(1'b0, 1'b0);
        frame_stats(1'b1, 1'b1);
        frame_stats(1'b0, 1'b1);

        for (int i = 0; i < 60; i++)
            step(1'b1, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0);

        // reset while the serializer is on data bit 4
        step(1'b1, 1'b1);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0);
        chk("pre_rst_ser", 32'(tx_if.SerEn), 32'd1);
        #2 RST = 1'b0;
        #1 check_outs(idle_e);
        q.delete();
        @(posedge CLK);
        @(negedge CLK);
        check_outs(idle_e);
        RST = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1);
        frame_stats(1'b0, 1'b1);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
